// File: rtl/fifo_v3.sv
// fifo_v3: synchronous FIFO built on a register array. It has an optional fall-through
// bypass and a DEPTH=0 pass-through mode.
//
// Parameters
//   FALL_THROUGH : 1 -> a push into an empty FIFO shows up on data_o in the same cycle
//   DATA_WIDTH   : element width when dtype is left at its default
//   DEPTH        : number of storage entries; 0 selects combinational pass-through
//   dtype        : element type (any packed type, including packed structs)
//
// Ports
//   clk_i      : clock; all state updates on the rising edge
//   rst_ni     : synchronous active-low reset (pointers and count only)
//   flush_i    : synchronous clear; overrides push/pop in the same cycle
//   testmode_i : accepted and ignored
//   full_o     : DEPTH entries stored
//   empty_o    : nothing available on data_o
//   usage_o    : stored-entry count, truncated to ADDR_DEPTH bits
//   data_i     : write data
//   push_i     : write request (dropped when full)
//   data_o     : head element, combinational read
//   pop_i      : read request (ignored when empty)
module fifo_v3 #(
    parameter bit           FALL_THROUGH = 1'b0,
    parameter int unsigned  DATA_WIDTH   = 32,
    parameter int unsigned  DEPTH        = 8,
    parameter type          dtype        = logic [DATA_WIDTH-1:0],
    localparam int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  testmode_i,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [ADDR_DEPTH-1:0] usage_o,
    input  dtype                  data_i,
    input  logic                  push_i,
    output dtype                  data_o,
    input  logic                  pop_i
);

    logic unused_testmode;
    assign unused_testmode = testmode_i;

    if (DEPTH == 0) begin : gen_pass_through
        // No storage: the producer talks straight to the consumer.
        assign data_o  = data_i;
        assign empty_o = ~push_i;
        assign full_o  = ~pop_i;
        assign usage_o = '0;

        logic unused_pass_through;
        assign unused_pass_through = ^{clk_i, rst_ni, flush_i};
    end else begin : gen_fifo
        localparam int unsigned               CntWidth  = ADDR_DEPTH + 1;
        localparam logic [ADDR_DEPTH-1:0]     LastAddr  = ADDR_DEPTH'(DEPTH - 1);
        localparam logic [CntWidth-1:0]       FullCount = CntWidth'(DEPTH);

        logic [ADDR_DEPTH-1:0] read_ptr_q, read_ptr_d;
        logic [ADDR_DEPTH-1:0] write_ptr_q, write_ptr_d;
        logic [CntWidth-1:0]   status_cnt_q, status_cnt_d;
        dtype                  mem_q [DEPTH];

        logic stored_empty;
        logic stored_full;
        logic bypass;
        logic push_ok;
        logic pop_ok;
        logic mem_we;

        // Pointers wrap explicitly so non-power-of-two depths stay in range.
        function automatic logic [ADDR_DEPTH-1:0] next_ptr(input logic [ADDR_DEPTH-1:0] ptr);
            return (ptr == LastAddr) ? '0 : ptr + 1'b1;
        endfunction

        assign stored_empty = (status_cnt_q == '0);
        assign stored_full  = (status_cnt_q == FullCount);
        // Fall-through: an empty FIFO presents the incoming element directly.
        assign bypass       = FALL_THROUGH && stored_empty && push_i;
        assign push_ok      = push_i && !stored_full;
        assign pop_ok       = pop_i && !stored_empty;

        // Next-state logic for pointers, count and memory write enable.
        always_comb begin
            read_ptr_d   = read_ptr_q;
            write_ptr_d  = write_ptr_q;
            status_cnt_d = status_cnt_q;
            mem_we       = 1'b0;

            if (bypass && pop_i) begin
                // Element is consumed in the cycle it arrives; nothing is stored.
            end else begin
                if (push_ok) begin
                    mem_we      = 1'b1;
                    write_ptr_d = next_ptr(write_ptr_q);
                end
                if (pop_ok) begin
                    read_ptr_d = next_ptr(read_ptr_q);
                end
                case ({push_ok, pop_ok})
                    2'b10:   status_cnt_d = status_cnt_q + 1'b1;
                    2'b01:   status_cnt_d = status_cnt_q - 1'b1;
                    default: status_cnt_d = status_cnt_q;
                endcase
            end

            if (flush_i) begin
                read_ptr_d   = '0;
                write_ptr_d  = '0;
                status_cnt_d = '0;
                mem_we       = 1'b0;
            end
        end

        // Outputs.
        always_comb begin
            full_o  = stored_full;
            empty_o = stored_empty && !bypass;
            usage_o = status_cnt_q[ADDR_DEPTH-1:0];
            data_o  = bypass ? data_i : mem_q[read_ptr_q];
        end

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                read_ptr_q   <= '0;
                write_ptr_q  <= '0;
                status_cnt_q <= '0;
            end else begin
                read_ptr_q   <= read_ptr_d;
                write_ptr_q  <= write_ptr_d;
                status_cnt_q <= status_cnt_d;
            end
        end

        // Storage is not reset; the count alone decides what is valid.
        always_ff @(posedge clk_i) begin
            if (mem_we) begin
                mem_q[write_ptr_q] <= data_i;
            end
        end
    end

`ifndef SYNTHESIS
    initial begin
        if (DEPTH > 0 && DATA_WIDTH == 0) begin
            $fatal(1, "fifo_v3: DATA_WIDTH must be non-zero when DEPTH > 0");
        end
    end
`endif

endmodule

// File: tb/tb_fifo_v3.sv
// Bench for fifo_v3: DEPTH=4 registered, DEPTH=4 fall-through and DEPTH=0 pass-through.
module tb_fifo_v3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // Instance A: DEPTH=4, FALL_THROUGH=0
    logic       a_flush, a_push, a_pop, a_full, a_empty;
    logic [7:0] a_din, a_dout;
    logic [1:0] a_usage;
    // Instance B: DEPTH=4, FALL_THROUGH=1
    logic       b_flush, b_push, b_pop, b_full, b_empty;
    logic [7:0] b_din, b_dout;
    logic [1:0] b_usage;
    // Instance C: DEPTH=0
    logic       c_flush, c_push, c_pop, c_full, c_empty;
    logic [7:0] c_din, c_dout;
    logic [0:0] c_usage;

    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(4)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush), .testmode_i(1'b0),
        .full_o(a_full), .empty_o(a_empty), .usage_o(a_usage),
        .data_i(a_din), .push_i(a_push), .data_o(a_dout), .pop_i(a_pop)
    );

    fifo_v3 #(.FALL_THROUGH(1'b1), .DATA_WIDTH(8), .DEPTH(4)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush), .testmode_i(1'b0),
        .full_o(b_full), .empty_o(b_empty), .usage_o(b_usage),
        .data_i(b_din), .push_i(b_push), .data_o(b_dout), .pop_i(b_pop)
    );

    fifo_v3 #(.FALL_THROUGH(1'b0), .DATA_WIDTH(8), .DEPTH(0)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .flush_i(c_flush), .testmode_i(1'b0),
        .full_o(c_full), .empty_o(c_empty), .usage_o(c_usage),
        .data_i(c_din), .push_i(c_push), .data_o(c_dout), .pop_i(c_pop)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Expected values describe the outputs just before the edge that applies the inputs.
    typedef struct {
        logic       push;
        logic       pop;
        logic       flush;
        logic [7:0] din;
        logic       exp_empty;
        logic       exp_full;
        logic [1:0] exp_usage;
        logic       chk_data;
        logic [7:0] exp_data;
    } vec_t;

    vec_t tbl [22];

    initial begin
        // push, pop, flush, din, empty, full, usage, chk_data, data
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h0A, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h0B, 1'b0, 1'b0, 2'd1, 1'b1, 8'h0A};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h0C, 1'b0, 1'b0, 2'd2, 1'b1, 8'h0A};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 8'h0D, 1'b0, 1'b0, 2'd3, 1'b1, 8'h0A};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h0E, 1'b0, 1'b1, 2'd0, 1'b1, 8'h0A};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b1, 8'h0A};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 2'd0, 1'b1, 8'h0A};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 1'b1, 8'h0B};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd2, 1'b1, 8'h0C};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd1, 1'b1, 8'h0D};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00};
        tbl[13] = '{1'b1, 1'b0, 1'b0, 8'h10, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 2'd1, 1'b1, 8'h10};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 2'd2, 1'b1, 8'h10};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 8'h13, 1'b0, 1'b0, 2'd3, 1'b1, 8'h10};
        // Full: push and pop together must perform only the pop.
        tbl[17] = '{1'b1, 1'b1, 1'b0, 8'h14, 1'b0, 1'b1, 2'd0, 1'b1, 8'h10};
        tbl[18] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 1'b1, 8'h11};
        tbl[19] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd3, 1'b1, 8'h11};
        tbl[20] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 2'd2, 1'b1, 8'h12};
        tbl[21] = '{1'b1, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 2'd1, 1'b1, 8'h13};
    end

    logic [7:0] model [$];

    initial begin
        rst_n   = 1'b0;
        a_flush = 1'b0; a_push = 1'b0; a_pop = 1'b0; a_din = 8'h00;
        b_flush = 1'b0; b_push = 1'b0; b_pop = 1'b0; b_din = 8'h00;
        c_flush = 1'b0; c_push = 1'b0; c_pop = 1'b0; c_din = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset empty", {31'b0, a_empty}, 32'd1);
        check("reset full",  {31'b0, a_full},  32'd0);
        check("reset usage", {30'b0, a_usage}, 32'd0);

        // Table: fill to full, dropped push, drain, pop on empty, full push+pop.
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            a_push  = tbl[i].push;
            a_pop   = tbl[i].pop;
            a_flush = tbl[i].flush;
            a_din   = tbl[i].din;
            #1;
            check($sformatf("v%0d empty", i), {31'b0, a_empty}, {31'b0, tbl[i].exp_empty});
            check($sformatf("v%0d full", i),  {31'b0, a_full},  {31'b0, tbl[i].exp_full});
            check($sformatf("v%0d usage", i), {30'b0, a_usage}, {30'b0, tbl[i].exp_usage});
            if (tbl[i].chk_data) begin
                check($sformatf("v%0d data", i), {24'b0, a_dout}, {24'b0, tbl[i].exp_data});
            end
        end

        // Two entries held; simultaneous push/pop for 10 cycles wraps both pointers.
        model = '{8'h13, 8'h20};
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            a_push = 1'b1;
            a_pop  = 1'b1;
            a_din  = 8'h30 + 8'(i);
            #1;
            check($sformatf("pp%0d usage", i), {30'b0, a_usage}, 32'd2);
            check($sformatf("pp%0d data", i),  {24'b0, a_dout},  {24'b0, model[0]});
            void'(model.pop_front());
            model.push_back(a_din);
        end
        @(negedge clk);
        a_push = 1'b0; a_pop = 1'b1;
        #1;
        check("after pp usage", {30'b0, a_usage}, 32'd2);
        check("after pp data",  {24'b0, a_dout},  32'h38);
        @(negedge clk);
        a_pop = 1'b0; a_push = 1'b1; a_din = 8'h40;
        #1;
        check("after pp data2", {24'b0, a_dout}, 32'h39);
        @(negedge clk);
        a_din = 8'h41;
        #1;
        check("pre-flush usage2", {30'b0, a_usage}, 32'd2);

        // Flush with three entries and a concurrent push.
        @(negedge clk);
        a_flush = 1'b1; a_din = 8'h42;
        #1;
        check("pre-flush usage3", {30'b0, a_usage}, 32'd3);
        @(negedge clk);
        a_flush = 1'b0; a_push = 1'b0;
        #1;
        check("flush empty", {31'b0, a_empty}, 32'd1);
        check("flush usage", {30'b0, a_usage}, 32'd0);

        // Synchronous reset with two entries.
        @(negedge clk);
        a_push = 1'b1; a_din = 8'h77;
        @(negedge clk);
        a_din = 8'h78;
        #1;
        check("post-flush data", {24'b0, a_dout}, 32'h77);
        @(negedge clk);
        a_push = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("pre-reset usage", {30'b0, a_usage}, 32'd2);
        check("pre-reset empty", {31'b0, a_empty}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post-reset empty", {31'b0, a_empty}, 32'd1);
        check("post-reset full",  {31'b0, a_full},  32'd0);
        check("post-reset usage", {30'b0, a_usage}, 32'd0);

        // Fall-through: push and pop together on empty bypasses storage.
        @(negedge clk);
        b_push = 1'b1; b_pop = 1'b1; b_din = 8'h55;
        #1;
        check("ft bypass data",  {24'b0, b_dout},  32'h55);
        check("ft bypass empty", {31'b0, b_empty}, 32'd0);
        @(negedge clk);
        b_push = 1'b0; b_pop = 1'b0;
        #1;
        check("ft after empty", {31'b0, b_empty}, 32'd1);
        check("ft after usage", {30'b0, b_usage}, 32'd0);
        @(negedge clk);
        b_push = 1'b1; b_din = 8'h66;
        #1;
        check("ft push data",  {24'b0, b_dout},  32'h66);
        check("ft push empty", {31'b0, b_empty}, 32'd0);
        @(negedge clk);
        b_push = 1'b0; b_din = 8'h00;
        #1;
        check("ft stored usage", {30'b0, b_usage}, 32'd1);
        check("ft stored data",  {24'b0, b_dout},  32'h66);
        @(negedge clk);
        b_pop = 1'b1;
        @(negedge clk);
        b_pop = 1'b0;
        #1;
        check("ft drained empty", {31'b0, b_empty}, 32'd1);

        // Pass-through mode.
        for (int i = 0; i < 4; i++) begin
            logic [1:0] sel;
            sel = 2'(i);
            @(negedge clk);
            c_din  = 8'hC0 + 8'(i);
            c_push = sel[0];
            c_pop  = sel[1];
            #1;
            check($sformatf("pt%0d data", i),  {24'b0, c_dout},  {24'b0, 8'hC0 + 8'(i)});
            check($sformatf("pt%0d empty", i), {31'b0, c_empty}, {31'b0, ~sel[0]});
            check($sformatf("pt%0d full", i),  {31'b0, c_full},  {31'b0, ~sel[1]});
            check($sformatf("pt%0d usage", i), {31'b0, c_usage}, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_v3.md
FIFO_V3 -- requirements
Module: fifo_v3

Interface
REQ-001 The module SHALL have parameter FALL_THROUGH, default 1'b0: when 1, data pushed into an empty FIFO appears on data_o in the same cycle.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32: element width in bits when dtype is left at its default.
REQ-003 The module SHALL have parameter DEPTH, default 8: number of storage entries; 0 selects pass-through mode.
REQ-004 The module SHALL have type parameter dtype, default logic[DATA_WIDTH-1:0]: element type, including packed structs.
REQ-005 The module SHALL derive localparam ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1.
REQ-006 The module SHALL have port clk_i, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-007 The module SHALL have port rst_ni, input, 1 bit: reset, synchronous and active-low.
REQ-008 The module SHALL have port flush_i, input, 1 bit: synchronous clear of all contents.
REQ-009 The module SHALL have port testmode_i, input, 1 bit: accepted and functionally ignored.
REQ-010 The module SHALL have port full_o, output, 1 bit: FIFO holds DEPTH entries.
REQ-011 The module SHALL have port empty_o, output, 1 bit: no data is available on data_o.
REQ-012 The module SHALL have port usage_o, output, ADDR_DEPTH bits: stored-entry count, truncated to ADDR_DEPTH bits.
REQ-013 The module SHALL have port data_i, input, dtype: write data.
REQ-014 The module SHALL have port push_i, input, 1 bit: write request.
REQ-015 The module SHALL have port data_o, output, dtype: head element (combinational read).
REQ-016 The module SHALL have port pop_i, input, 1 bit: read request.

Function
REQ-017 State SHALL be: read pointer and write pointer (ADDR_DEPTH bits each), status counter (ADDR_DEPTH+1 bits), and a DEPTH-entry memory.
REQ-018 full_o SHALL equal (status counter == DEPTH); empty_o SHALL equal (status counter == 0), except as stated in REQ-022.
REQ-019 push_i with full_o=0 SHALL write data_i at the write pointer, increment the write pointer (wrapping DEPTH-1 to 0) and increment the counter; push_i with full_o=1 SHALL be ignored, data dropped.
REQ-020 pop_i with empty_o=0 SHALL increment the read pointer (wrapping DEPTH-1 to 0) and decrement the counter; pop_i with empty_o=1 SHALL be ignored.
REQ-021 A simultaneous accepted push and accepted pop SHALL leave the counter unchanged while both pointers advance; when full, push_i and pop_i together SHALL perform only the pop.
REQ-022 FALL_THROUGH=1 with counter 0 and push_i=1: data_o SHALL equal data_i and empty_o SHALL be 0 combinationally; if pop_i is also 1, the element SHALL bypass memory and pointers and counter SHALL stay unchanged.
REQ-023 FALL_THROUGH=0: a pushed element SHALL be visible on data_o from the cycle after the push (latency 1).
REQ-024 data_o SHALL show memory at the read pointer whenever the bypass of REQ-022 is not active; its value while empty is don't-care.
REQ-025 flush_i=1 SHALL clear both pointers and the counter at the next edge, with priority over push and pop in the same cycle.
REQ-026 DEPTH=0 SHALL be pass-through: data_o=data_i, empty_o=~push_i, full_o=~pop_i, usage_o=0, no storage.
REQ-027 Out-of-range parameters (DEPTH>0 with DATA_WIDTH=0) SHALL raise $fatal in a simulation-only initial block.

Reset
REQ-028 With rst_ni=0 at a rising edge, pointers and counter SHALL become 0, so that empty_o=1, full_o=0 and usage_o=0; reset SHALL have priority over flush, push and pop; memory contents need not be reset.

Structure
REQ-029 The module SHALL be self-contained with no shared-package typedefs or constants, since the element type arrives through dtype.
REQ-030 The module SHALL have no sub-module; the memory SHALL be a register array.

Verification
REQ-031 Bench: DEPTH=4, FALL_THROUGH=0 -> push 0xA,0xB,0xC,0xD -> full_o=1 with usage_o=0 (truncated); a fifth push of 0xE is dropped; popping four times yields A,B,C,D, then empty_o=1.
REQ-032 Bench: FALL_THROUGH=1, empty FIFO, push_i=pop_i=1 with data 0x55 in one cycle -> data_o=0x55 and empty_o=0 in that cycle; afterwards the counter is 0 and empty_o=1.
REQ-033 Bench: DEPTH=4 with 2 entries, push and pop together for 10 cycles -> usage_o stays 2, order is preserved and pointers wrap.
REQ-034 Bench: 3 entries, flush_i=1 together with push_i=1 -> next cycle empty_o=1 and usage_o=0.
REQ-035 Bench: 2 entries, rst_ni=0 for one edge mid-operation -> empty_o=1 and full_o=0 after that edge; no change is seen before the edge (synchronous).
REQ-036 Bench: DEPTH=0 -> data_o tracks data_i, and empty_o/full_o follow ~push_i/~pop_i combinationally.
